// File: rtl/pid_scan_sched_pkg.sv
// rtl/pid_scan_sched_pkg.sv - scan FSM state encoding and channel-pick helper for pid_scan_sched
package pid_scan_sched_pkg;

  // Widest channel mask the helper searches; CH_NUM is limited to 2..8.
  localparam int MAX_CH = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADC_REQ,
    S_ADC_WAIT,
    S_PID_REQ,
    S_PID_WAIT,
    S_NEXT
  } state_t;

  typedef struct packed {
    logic       hit;
    logic [2:0] idx;
  } pick_t;

  // Lowest set bit of a channel mask; hit=0 when the mask is empty.
  function automatic pick_t lowest_set(input logic [MAX_CH-1:0] mask);
    pick_t p;
    p = '0;
    for (int i = MAX_CH - 1; i >= 0; i--) begin
      if (mask[i]) begin
        p.hit = 1'b1;
        p.idx = 3'(i);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/pid_ramp.sv
// rtl/pid_ramp.sv - per-channel soft-start target ramp, built only when SOFT_START_EN is defined
`ifdef SOFT_START_EN
module pid_ramp #(
  parameter int OW        = 26,
  parameter int RAMP_STEP = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          tick,
  input  logic [OW-1:0] target,
  output logic [OW-1:0] ramp_next
);

  localparam logic [OW-1:0] STEP = OW'(RAMP_STEP);

  logic [OW-1:0] ramp;

  // Next ramp value: parked at 0 while disabled, one step toward target per tick, never past it.
  always_comb begin
    ramp_next = ramp;
    if (!en) begin
      ramp_next = '0;
    end else if (tick) begin
      if (ramp < target) begin
        ramp_next = ((target - ramp) > STEP) ? ramp + STEP : target;
      end else if (ramp > target) begin
        ramp_next = ((ramp - target) > STEP) ? ramp - STEP : target;
      end
    end
  end

  // Ramp register; the scheduler latches ramp_next so a channel started on a tick sees the new step.
  always_ff @(posedge clk) begin
    if (rst) ramp <= '0;
    else     ramp <= ramp_next;
  end

endmodule
`endif

// File: rtl/pid_scan_sched.sv
// rtl/pid_scan_sched.sv - round-robin scan of CH_NUM loops over one ADC and one PID core (option SOFT_START_EN)
module pid_scan_sched
  import pid_scan_sched_pkg::*;
#(
  parameter int CH_NUM     = 4,
  parameter int DW         = 12,
  parameter int OW         = 26,
  parameter int PERIOD_CYC = 1000,
  parameter int ADC_TMO    = 255,
  parameter int RAMP_STEP  = 1,
  localparam int CHW       = $clog2(CH_NUM)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [CH_NUM-1:0]    ch_en,
  input  logic                 fault_clr,
  input  logic [CH_NUM*OW-1:0] target_flat,
  output logic                 adc_start,
  output logic [CHW-1:0]       adc_ch,
  input  logic                 adc_done,
  input  logic [DW-1:0]        adc_data,
  output logic                 pid_valid,
  output logic [CHW-1:0]       pid_ch,
  output logic [DW-1:0]        pid_sample,
  output logic [OW-1:0]        pid_target,
  input  logic                 pid_done,
  input  logic [OW-1:0]        pid_out,
  output logic [CH_NUM*OW-1:0] out_flat,
  output logic [CH_NUM-1:0]    out_stb,
  output logic [CH_NUM-1:0]    adc_fault,
  output logic                 overrun
);

  localparam int PW = $clog2(PERIOD_CYC);
  localparam int TW = $clog2(ADC_TMO + 1);

  state_t            state;
  logic [PW-1:0]     per_cnt;
  logic              tick;
  logic [CHW-1:0]    ch;
  logic [CH_NUM-1:0] scan_mask;
  logic [TW-1:0]     tmo_cnt;
  logic [MAX_CH-1:0] above;
  pick_t             pick_idle;
  pick_t             pick_next;
  logic [CHW-1:0]    nxt_ch;
  logic [OW-1:0]     nxt_target;

  assign tick = en && (per_cnt == PW'(PERIOD_CYC - 1));

  // Control-period counter: free-runs while enabled, parked at 0 otherwise.
  always_ff @(posedge clk) begin
    if (rst || !en)  per_cnt <= '0;
    else if (tick)   per_cnt <= '0;
    else             per_cnt <= per_cnt + PW'(1);
  end

  // Channel to start next: lowest enabled on a fresh scan, next higher in the scan mask afterwards.
  always_comb begin
    above = '0;
    for (int i = 0; i < CH_NUM; i++) begin
      above[i] = scan_mask[i] && (i > int'(ch));
    end
    pick_idle = lowest_set(MAX_CH'(ch_en));
    pick_next = lowest_set(above);
    nxt_ch    = (state == S_IDLE) ? CHW'(pick_idle.idx) : CHW'(pick_next.idx);
  end

`ifdef SOFT_START_EN
  logic [OW-1:0] ramp_nxt [CH_NUM];

  for (genvar g = 0; g < CH_NUM; g++) begin : g_ramp
    pid_ramp #(
      .OW        (OW),
      .RAMP_STEP (RAMP_STEP)
    ) u_ramp (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .tick      (tick),
      .target    (target_flat[g*OW +: OW]),
      .ramp_next (ramp_nxt[g])
    );
  end

  assign nxt_target = ramp_nxt[nxt_ch];
`else
  logic unused_ramp_step;

  assign nxt_target       = target_flat[int'(nxt_ch)*OW +: OW];
  assign unused_ramp_step = (RAMP_STEP != 0);
`endif

  // Scan FSM with registered datapath handshakes, result capture and sticky status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      ch         <= '0;
      scan_mask  <= '0;
      tmo_cnt    <= '0;
      adc_start  <= 1'b0;
      adc_ch     <= '0;
      pid_valid  <= 1'b0;
      pid_ch     <= '0;
      pid_sample <= '0;
      pid_target <= '0;
      out_flat   <= '0;
      out_stb    <= '0;
      adc_fault  <= '0;
      overrun    <= 1'b0;
    end else begin
      out_stb   <= '0;
      adc_start <= 1'b0;
      // Clear first so a fault or overrun raised in the same cycle survives.
      if (fault_clr) begin
        adc_fault <= '0;
        overrun   <= 1'b0;
      end
      if (tick && (state != S_IDLE)) overrun <= 1'b1;

      case (state)
        S_IDLE: begin
          if (tick && pick_idle.hit) begin
            scan_mask  <= ch_en;
            ch         <= nxt_ch;
            adc_ch     <= nxt_ch;
            pid_ch     <= nxt_ch;
            pid_target <= nxt_target;
            adc_start  <= 1'b1;
            state      <= S_ADC_REQ;
          end
        end
        S_ADC_REQ: begin
          tmo_cnt <= '0;
          state   <= S_ADC_WAIT;
        end
        S_ADC_WAIT: begin
          if (adc_done) begin
            pid_sample <= adc_data;
            pid_valid  <= 1'b1;
            state      <= S_PID_REQ;
          end else if (tmo_cnt == TW'(ADC_TMO - 1)) begin
            adc_fault[ch] <= 1'b1;
            state         <= S_NEXT;
          end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
          end
        end
        S_PID_REQ, S_PID_WAIT: begin
          if (pid_done) begin
            out_flat[int'(ch)*OW +: OW] <= pid_out;
            out_stb[ch]                 <= 1'b1;
            pid_valid                   <= 1'b0;
            state                       <= S_NEXT;
          end else begin
            state <= S_PID_WAIT;
          end
        end
        S_NEXT: begin
          if (en && pick_next.hit) begin
            ch         <= nxt_ch;
            adc_ch     <= nxt_ch;
            pid_ch     <= nxt_ch;
            pid_target <= nxt_target;
            adc_start  <= 1'b1;
            state      <= S_ADC_REQ;
          end else begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
